// File: rtl/siso_ctrl_pkg.sv
// Shared types and constants for the SISO shift-register sequencer.
// Imported by the handshake interface, capture unit and controller top.
package siso_ctrl_pkg;

  localparam int SISO_WIDTH_DEFAULT = 16;
  localparam int SISO_LOAD_CYCLES   = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } siso_ctrl_state_t;

endpackage

// File: rtl/siso_shift_controller_if.sv
// Request/result valid-ready bundle for the SISO shift controller.
// master = datapath side, slave = controller side.
interface siso_shift_controller_if
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = SISO_WIDTH_DEFAULT
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_left;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid,
    output in_data,
    output in_left,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_left,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err
  );

endinterface

// File: rtl/siso_shift_capture.sv
// Direction-aware serial-to-parallel capture register and bit counter.
// last flags the final SHIFT cycle so the FSM can leave on that edge.
module siso_shift_capture
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = SISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             left,
  input  logic             dout,
  output logic [WIDTH-1:0] cap,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0] cnt;

  assign last = en && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      if (left)
        cap <= {cap[WIDTH-2:0], dout};
      else
        cap <= {dout, cap[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/siso_shift_controller.sv
// Sequencer driving one SISO shift register; optional result check
// is enabled by defining SISO_SHIFT_CTRL_CHECK_EN.
module siso_shift_controller
  import siso_ctrl_pkg::*;
#(
  parameter int   WIDTH    = SISO_WIDTH_DEFAULT,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  siso_shift_controller_if.slave  bus,
  output logic                    busy,
  output logic                    Load,
  output logic                    Left,
  output logic                    Din,
  output logic [WIDTH-1:0]        A,
  input  logic                    Dout
);

  siso_ctrl_state_t state_q, state_d;

  logic [WIDTH-1:0] word_q;
  logic             left_q;
  logic [WIDTH-1:0] cap;
  logic             last;
  logic             accept;

  assign accept = bus.in_valid && (state_q == IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      left_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q <= bus.in_data;
        left_q <= bus.in_left;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.in_valid) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (last) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
    endcase
  end

  siso_shift_capture #(
    .WIDTH (WIDTH)
  ) u_cap (
    .clk  (Clk),
    .rst  (Rst),
    .clr  (accept),
    .en   (state_q == SHIFT),
    .left (left_q),
    .dout (Dout),
    .cap  (cap),
    .last (last)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = cap;

  assign busy = (state_q != IDLE);
  assign Load = (state_q == LOAD);
  assign Left = left_q;
  assign A    = word_q;
  assign Din  = FILL_BIT;

`ifdef SISO_SHIFT_CTRL_CHECK_EN
  // Held only while the result is presented; drops with DONE.
  assign bus.out_err = (state_q == DONE) && (cap != word_q);
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_shift_controller.sv
// Directed bench for siso_shift_controller with a behavioural
// shift-register model on the Load/A/Left/Din/Dout pins.
module tb_siso_shift_controller;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy, load, left, din, dout;
  logic [W-1:0]  a;
  logic [W-1:0]  sr = '0;
  logic          flip = 1'b0;

  int checks = 0;
  int errors = 0;

  siso_shift_controller_if #(.WIDTH(W)) bus ();

  siso_shift_controller #(
    .WIDTH    (W),
    .FILL_BIT (1'b0)
  ) dut (
    .Clk  (clk),
    .Rst  (rst),
    .bus  (bus),
    .busy (busy),
    .Load (load),
    .Left (left),
    .Din  (din),
    .A    (a),
    .Dout (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load)
      sr <= a;
    else if (left)
      sr <= {sr[W-2:0], din};
    else
      sr <= {din, sr[W-1:1]};
  end

  assign dout = (left ? sr[W-1] : sr[0]) ^ flip;

  typedef struct {
    logic [W-1:0] data;
    logic         left;
    int           hold;
    int           flip_k;
    logic [W-1:0] exp_data;
    logic         exp_err_chk;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1)
      chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic do_txn(input string name, input vec_t v);
    int k = 1;
    int vk = 0;
    int loads = 0;
    int idx;
    bit got = 0;
    bit dok = 1;
    bit rdy_bad = 0;
    bit hold_ok = 1;
    logic expbit;
    logic exp_err;
    logic [W-1:0] held;

`ifdef SISO_SHIFT_CTRL_CHECK_EN
    exp_err = v.exp_err_chk;
`else
    exp_err = 1'b0;
`endif

    wait_ready(name);
    bus.in_data   = v.data;
    bus.in_left   = v.left;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;

    while (k <= 30 && !got) begin
      flip = 1'b0;
      #1;
      if (k == 1) begin
        chk({name, "_A"}, a, v.data);
        chk({name, "_Left"}, left, v.left);
      end
      if (load) loads++;
      if (k >= 2 && k <= 17) begin
        idx = v.left ? (W - 1 - (k - 2)) : (k - 2);
        expbit = v.data[idx];
        if (dout !== expbit) dok = 0;
      end
      if (bus.in_ready !== 1'b0) rdy_bad = 1;
      if (bus.out_valid === 1'b1) begin
        got = 1;
        vk = k;
      end else begin
        flip = (k == v.flip_k);
        @(negedge clk);
        k++;
      end
    end
    flip = 1'b0;

    chk({name, "_latency"}, vk, 18);
    chk({name, "_load_pulses"}, loads, 1);
    chk({name, "_dout_seq"}, dok, 1);
    chk({name, "_in_ready_low"}, rdy_bad, 0);

    held = bus.out_data;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 ||
          bus.out_data !== held ||
          bus.in_ready !== 1'b0)
        hold_ok = 0;
    end
    if (v.hold > 0)
      chk({name, "_hold_stable"}, hold_ok, 1);

    chk({name, "_out_data"}, bus.out_data, v.exp_data);
    chk({name, "_out_err"}, bus.out_err, exp_err);

    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_release"},
        {bus.out_valid, bus.in_ready, bus.out_err},
        3'b010);
  endtask

  initial begin
    vec_t fv;
    logic [W-1:0] b2b [3];
    int nacc;
    int nout;
    int last_acc;
    bit gap_ok;
    bit excl_ok;
    bit quiet;
    bit pend;

    vecs[0] = '{16'hA5C3, 1'b1, 0, 0,  16'hA5C3, 1'b0};
    vecs[1] = '{16'h0001, 1'b0, 0, 0,  16'h0001, 1'b0};
    vecs[2] = '{16'h1234, 1'b1, 5, 0,  16'h1234, 1'b0};
    vecs[3] = '{16'h8000, 1'b0, 0, 0,  16'h8000, 1'b0};
    vecs[4] = '{16'hA5C3, 1'b1, 0, 10, 16'hA543, 1'b1};
    vecs[5] = '{16'h00F0, 1'b0, 0, 10, 16'h01F0, 1'b1};
    vecs[6] = '{16'hFFFF, 1'b0, 2, 0,  16'hFFFF, 1'b0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_left   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pins", {load, left, din}, 3'b000);
    chk("rst_A", a, 0);

    for (int i = 0; i < 7; i++)
      do_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset during the 7th SHIFT cycle, with in_valid raised alongside.
    wait_ready("rst_mid");
    bus.in_data  = 16'h5A5A;
    bus.in_left  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_mid_state",
        {busy, load, bus.in_ready, bus.out_valid},
        4'b0010);
    quiet = 1;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || busy !== 1'b0)
        quiet = 0;
    end
    chk("rst_mid_quiet", quiet, 1);
    fv = '{16'hFFFF, 1'b1, 0, 0, 16'hFFFF, 1'b0};
    do_txn("after_rst", fv);

    // Back-to-back with in_valid held and out_ready high.
    b2b[0] = 16'h1111;
    b2b[1] = 16'h2C3D;
    b2b[2] = 16'hF00E;
    nacc = 0;
    nout = 0;
    last_acc = 0;
    gap_ok = 1;
    excl_ok = 1;
    pend = 0;
    bus.out_ready = 1'b1;
    bus.in_data   = b2b[0];
    bus.in_left   = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 120 && nout < 3; c++) begin
      if (pend) begin
        pend = 0;
        if (nacc < 3) begin
          bus.in_data = b2b[nacc];
          bus.in_left = nacc[0];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1)
        excl_ok = 0;
      if (bus.out_valid === 1'b1) begin
        chk($sformatf("b2b_data%0d", nout),
            bus.out_data, b2b[nout]);
        nout++;
      end
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
        if (nacc > 0 && c - last_acc != 19) gap_ok = 0;
        last_acc = c;
        nacc++;
        pend = 1;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_results", nout, 3);
    chk("b2b_spacing", gap_ok, 1);
    chk("b2b_exclusive", excl_ok, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/siso_shift_controller.md
# siso_shift_controller

Sequencer for the 16-bit SISO FIFO shift register. It accepts a parallel word and a direction over a valid/ready handshake, then drives the register's `Load`, `A`, `Left` and `Din` pins to shift the word out one bit per clock. It reassembles the serial `Dout` stream into a parallel result word and returns it over a second valid/ready handshake. It sits between the system datapath and a single shift-register instance and is the only agent allowed to drive that instance.

## Interface
Parameters:
- `WIDTH`, 16: shift-register width in bits; must match the register instance.
- `FILL_BIT`, 1'b0: value driven on `Din` during shifting.

Ports:
- `Clk`, in, 1: clock; all state updates on the rising edge.
- `Rst`, in, 1: synchronous reset, active-high.
- `in_valid`, in, 1: request word present.
- `in_ready`, out, 1: controller can accept a request.
- `in_data`, in, WIDTH: word to shift.
- `in_left`, in, 1: direction (1 = MSB first, 0 = LSB first).
- `out_valid`, out, 1: result word present.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, WIDTH: reassembled word.
- `out_err`, out, 1: check mismatch flag (see Configuration).
- `busy`, out, 1: high in every state except IDLE.
- `Load`, out, 1: to register; parallel-load strobe.
- `Left`, out, 1: to register; shift direction.
- `Din`, out, 1: to register; serial input.
- `A`, out, WIDTH: to register; parallel load value.
- `Dout`, in, 1: from register; bit leaving on the next shift edge.

## Operation
- Register contract: when `Load`=1 at an edge, `register <= A`. When `Load`=0, it shifts one place toward `Left` and inserts `Din`. `Dout` is the current MSB when `Left`=1 and the current LSB when `Left`=0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - `in_valid`&&`in_ready` latches `in_data` and `in_left`, clears the bit counter, and moves to LOAD.
- LOAD (exactly 1 cycle):
  - `Load`=1, `A`=latched word, `Left`=latched direction.
  - Moves to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - `Load`=0, `Din`=`FILL_BIT`.
  - Each edge samples `Dout` into the capture register: `{cap[W-2:0],Dout}` when Left=1, `{Dout,cap[W-1:1]}` when Left=0.
  - The counter increments on each edge; the FSM leaves SHIFT on the edge where the counter reaches WIDTH-1.
- DONE:
  - `out_valid`=1 and `out_data`=capture register, both held stable until `out_ready`.
  - `out_valid`&&`out_ready` moves to IDLE.
- `Left` and `A` hold the latched values from LOAD through DONE. In IDLE they hold their last values, and `A` is 0 after reset.
- Backpressure: no new request is accepted until DONE completes. The controller processes one request at a time.
- Counter width is $clog2(WIDTH)+1 bits. The counter never wraps.

## Timing
- Accept edge T → LOAD during cycle T+1 → SHIFT during cycles T+2..T+WIDTH+1 → `out_valid` high from cycle T+WIDTH+2.
- With WIDTH=16, `out_valid` rises 18 cycles after the accept edge.
- Minimum request-to-request spacing is WIDTH+3 cycles: the DONE handshake takes 1 cycle, then IDLE takes 1 cycle.
- `in_ready` and `out_valid` are never high in the same cycle.
- Reset values: state=IDLE, `in_ready`=1 (in the first cycle after reset), `out_valid`=0, `out_data`=0, `out_err`=0, `busy`=0, `Load`=0, `Left`=0, `Din`=`FILL_BIT`, `A`=0, counter=0.
- `Rst` asserted in any state returns the FSM to IDLE on that edge and discards any in-flight word. No partial result is emitted.
- An `in_valid` that arrives in the same cycle as `Rst` is ignored.

## Configuration
- Macro: `SISO_SHIFT_CTRL_CHECK_EN`.
- When defined:
  - On entry to DONE, `out_err` = (capture register != latched input word).
  - `out_err` is valid while `out_valid`=1 and clears on the DONE→IDLE transition.
- When undefined:
  - `out_err` is tied to 0.
  - The latched-word comparator is removed.
  - The port remains present.

## Structure
- Shared package `siso_ctrl_pkg` holds:
  - the state enum `siso_ctrl_state_t` (IDLE, LOAD, SHIFT, DONE);
  - `SISO_WIDTH_DEFAULT`=16;
  - `SISO_LOAD_CYCLES`=1.
- One sub-module is natural: `siso_shift_capture`, holding the direction-aware capture register and the bit counter.
- The FSM, the request latch and the check logic stay in the top module.

## Test plan
- Reset, then `in_data`=16'hA5C3, `in_left`=1 → `Load` pulses once with `A`=16'hA5C3; `Dout` sequence is 1,0,1,0,0,1,0,1,…; `out_valid` at cycle 18 with `out_data`=16'hA5C3, `out_err`=0.
- `in_data`=16'h0001, `in_left`=0 → first sampled `Dout`=1; `out_data`=16'h0001 after 18 cycles.
- Hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `out_data` stay stable and `in_ready` stays 0; the second request is accepted only after the handshake.
- Assert `Rst` during the 7th SHIFT cycle → next cycle state is IDLE, `Load`=0, `out_valid` never rises; a fresh 16'hFFFF request completes normally.
- With `SISO_SHIFT_CTRL_CHECK_EN` defined, force one `Dout` bit flipped in cycle 10 → `out_err`=1 alongside `out_valid`; without the macro, `out_err`=0.
- Back-to-back requests with `in_valid` held high and `out_ready`=1 → accepts spaced exactly 19 cycles apart, results in order.
